// File: rtl/fifo_rd_pkg.sv
// Shared constants, types and width helpers for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BUF_DEPTH_DEF  = 4;
    localparam int PKT_LEN_DEF    = 16;

    localparam int PTR_W = $clog2(BUF_DEPTH_DEF);
    localparam int OCC_W = $clog2(BUF_DEPTH_DEF + 1);

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

    // Index width that stays at least one bit wide for degenerate sizes of 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_stream_buf.sv
// Circular skid buffer that absorbs the FIFO read latency; clear drops all held entries.
module rd_stream_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    localparam int PW        = idx_width(BUF_DEPTH),
    localparam int OW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OW-1:0]         occ_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [OW-1:0]         occ_q, occ_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (clear_i) begin
            occ_d  = '0;
            rptr_d = wptr_q;
        end else begin
            if (push_i) wptr_d = wptr_q + PW'(1);
            if (pop_i)  rptr_d = rptr_q + PW'(1);
            occ_d = occ_q + OW'(push_i) - OW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage carries no reset; the output mux hides stale entries instead.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= push_data_i;
    end

    assign occ_o     = occ_q;
    assign rd_data_o = (occ_q != '0) ? mem_q[rptr_q] : '0;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !clear_i && occ_q == OW'(BUF_DEPTH)));
`endif

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: credit-limited reads into a small buffer,
// presented as a valid/ready stream with fixed-length packet framing.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int PKT_LEN    = PKT_LEN_DEF
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           pkt_cnt
);

    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int IW = idx_width(PKT_LEN);

    logic [OW-1:0] occ;
    logic [OW:0]   credit_used;
    logic          inflight_q, inflight_d;
    logic [IW-1:0] word_idx_q, word_idx_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic          push, accept;

    // Credits count words already held plus the one read still in flight; m_ready never enters here.
    assign credit_used = {1'b0, occ} + (OW+1)'(inflight_q);
    assign fifo_ren    = ~rd_rst & enable & ~flush & ~fifo_empty
                       & (credit_used < (OW+1)'(BUF_DEPTH));

    assign push    = inflight_q & ~flush;
    assign m_valid = (occ != '0);
    assign m_last  = m_valid & (word_idx_q == IW'(PKT_LEN - 1));
    assign accept  = m_valid & m_ready & ~flush;
    assign pkt_cnt = pkt_cnt_q;

    rd_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk_i       (rd_clk),
        .rst_i       (rd_rst),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (fifo_dout),
        .pop_i       (accept),
        .occ_o       (occ),
        .rd_data_o   (m_data)
    );

    always_comb begin
        inflight_d = fifo_ren;
        word_idx_d = word_idx_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (flush) begin
            word_idx_d = '0;
        end else if (accept) begin
            if (m_last) begin
                word_idx_d = '0;
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
            end else begin
                word_idx_d = word_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight_q <= 1'b0;
            word_idx_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            word_idx_q <= word_idx_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_no_ren_when_empty: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(fifo_ren && fifo_empty));
    a_hold_under_backpressure: assert property (@(posedge rd_clk) disable iff (rd_rst)
        (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data) && $stable(m_last)));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port and an output monitor.
module tb_fifo_rd_stream;
    import fifo_rd_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 1 << PTR_W;
    localparam int PLEN  = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          m_ready = 1'b0;
    logic          hold_empty = 1'b0;
    logic          fifo_empty, fifo_ren, m_valid, m_last;
    logic [DW-1:0] fifo_dout, m_data;
    logic [15:0]   pkt_cnt;

    word_t fmem  [0:16383];
    word_t odata [0:16383];
    logic  olast [0:16383];
    int    fhead = 0, ftail = 0, mon_n = 0, ren_cnt = 0;
    int    checks = 0, errors = 0;

    fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .PKT_LEN(PLEN)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_ren   (fifo_ren),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO read port model: registered data, one cycle after an accepted read.
    assign fifo_empty = (fhead == ftail) || hold_empty;
    always @(posedge rd_clk) begin
        if (fifo_ren) begin
            fifo_dout <= fmem[fhead[13:0]];
            fhead     <= fhead + 1;
        end
    end

    always @(posedge rd_clk) begin
        if (fifo_ren) ren_cnt <= ren_cnt + 1;
        if (!rd_rst && m_valid && m_ready && !flush) begin
            odata[mon_n[13:0]] <= m_data;
            olast[mon_n[13:0]] <= m_last;
            mon_n              <= mon_n + 1;
        end
    end

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[ftail[13:0]] = word_t'(base + i);
            ftail = ftail + 1;
        end
    endtask

    task automatic wait_words(input int n0, input int n, input int budget);
        int k = 0;
        while ((mon_n - n0) < n && k < budget) begin
            @(negedge rd_clk);
            k++;
        end
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        flush = 1'b0;
        hold_empty = 1'b0;
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        push_words(32'hA5, 1);
        repeat (3) @(negedge rd_clk);
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL rst_ren got=%b want=0", fifo_ren); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", m_valid); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt got=%0d want=0", pkt_cnt); end
        checks++; if (m_data !== '0 || m_last !== 1'b0) begin errors++; $display("FAIL rst_data got=%h/%b want=0/0", m_data, m_last); end
        rd_rst = 1'b0;
        #1;
        checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL rst_first_ren got=%b want=1", fifo_ren); end
        @(negedge rd_clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid got=%b want=0", m_valid); end
        @(negedge rd_clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hA5) begin errors++; $display("FAIL lat_n2 got=%b/%h want=1/a5", m_valid, m_data); end
        repeat (2) @(negedge rd_clk);
    endtask

    task automatic test_streaming();
        int n0;
        do_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        n0 = mon_n;
        push_words(0, 64);
        repeat (65) @(negedge rd_clk);
        checks++; if (mon_n - n0 !== 63) begin errors++; $display("FAIL stream_rate got=%0d want=63", mon_n - n0); end
        @(negedge rd_clk);
        checks++; if (mon_n - n0 !== 64) begin errors++; $display("FAIL stream_count got=%0d want=64", mon_n - n0); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (odata[n0+i] !== word_t'(i) || olast[n0+i] !== (i % 16 == 15)) begin
                errors++; $display("FAIL stream_word[%0d] got=%h/%b want=%h/%b", i, odata[n0+i], olast[n0+i], i, (i % 16 == 15));
            end
        end
        checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL stream_pkt got=%0d want=4", pkt_cnt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b want=0", m_valid); end
    endtask

    task automatic test_backpressure();
        int n0, r0;
        do_reset();
        enable = 1'b1;
        m_ready = 1'b0;
        n0 = mon_n;
        r0 = ren_cnt;
        push_words(100, 8);
        repeat (10) @(negedge rd_clk);
        checks++; if (ren_cnt - r0 !== DEPTH) begin errors++; $display("FAIL bp_reads got=%0d want=%0d", ren_cnt - r0, DEPTH); end
        checks++; if (m_valid !== 1'b1 || m_data !== 32'd100) begin errors++; $display("FAIL bp_head got=%b/%0d want=1/100", m_valid, m_data); end
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL bp_ren got=%b want=0", fifo_ren); end
        @(negedge rd_clk);
        checks++; if (m_data !== 32'd100 || mon_n != n0) begin errors++; $display("FAIL bp_hold got=%0d/%0d want=100/0", m_data, mon_n - n0); end
        m_ready = 1'b1;
        wait_words(n0, 8, 50);
        repeat (3) @(negedge rd_clk);
        checks++; if (mon_n - n0 !== 8) begin errors++; $display("FAIL bp_count got=%0d want=8", mon_n - n0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (odata[n0+i] !== word_t'(100 + i) || olast[n0+i] !== 1'b0) begin
                errors++; $display("FAIL bp_word[%0d] got=%0d/%b want=%0d/0", i, odata[n0+i], olast[n0+i], 100 + i);
            end
        end
    endtask

    task automatic test_empty_boundary();
        int n0;
        do_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        n0 = mon_n;
        push_words(200, 3);
        repeat (2) @(negedge rd_clk);
        checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL empty_ren_before got=%b want=1", fifo_ren); end
        @(negedge rd_clk);
        checks++; if (fifo_empty !== 1'b1 || fifo_ren !== 1'b0) begin errors++; $display("FAIL empty_ren_drop got=%b/%b want=1/0", fifo_empty, fifo_ren); end
        repeat (3) @(negedge rd_clk);
        checks++; if (mon_n - n0 !== 3 || m_valid !== 1'b0) begin errors++; $display("FAIL empty_drain got=%0d/%b want=3/0", mon_n - n0, m_valid); end
        repeat (5) @(negedge rd_clk);
        push_words(203, 13);
        wait_words(n0, 16, 60);
        checks++; if (mon_n - n0 !== 16) begin errors++; $display("FAIL empty_resume_count got=%0d want=16", mon_n - n0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (odata[n0+i] !== word_t'(200 + i) || olast[n0+i] !== (i == 15)) begin
                errors++; $display("FAIL empty_word[%0d] got=%0d/%b want=%0d/%b", i, odata[n0+i], olast[n0+i], 200 + i, (i == 15));
            end
        end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL empty_pkt got=%0d want=1", pkt_cnt); end
    endtask

    task automatic test_flush();
        int n0, n1;
        do_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        n0 = mon_n;
        push_words(280, 18);
        wait_words(n0, 18, 60);
        repeat (2) @(negedge rd_clk);
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL flush_pre_pkt got=%0d want=1", pkt_cnt); end
        m_ready = 1'b0;
        push_words(300, 3);
        repeat (3) @(negedge rd_clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'd300) begin errors++; $display("FAIL flush_pre_head got=%b/%0d want=1/300", m_valid, m_data); end
        flush = 1'b1;
        n1 = mon_n;
        @(negedge rd_clk);
        flush = 1'b0;
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL flush_clear got=%b/%b want=0/0", m_valid, m_last); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL flush_pkt_kept got=%0d want=1", pkt_cnt); end
        repeat (3) @(negedge rd_clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight_dropped got=%b want=0", m_valid); end
        m_ready = 1'b1;
        push_words(400, 16);
        wait_words(n1, 16, 60);
        repeat (3) @(negedge rd_clk);
        checks++; if (mon_n - n1 !== 16) begin errors++; $display("FAIL flush_after_count got=%0d want=16", mon_n - n1); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (odata[n1+i] !== word_t'(400 + i) || olast[n1+i] !== (i == 15)) begin
                errors++; $display("FAIL flush_word[%0d] got=%0d/%b want=%0d/%b", i, odata[n1+i], olast[n1+i], 400 + i, (i == 15));
            end
        end
        checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL flush_post_pkt got=%0d want=2", pkt_cnt); end
    endtask

    task automatic test_random();
        int n0;
        int k;
        do_reset();
        n0 = mon_n;
        push_words(5000, 2000);
        k = 0;
        while ((mon_n - n0) < 2000 && k < 20000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            hold_empty = ($urandom_range(0, 7) == 0);
            @(negedge rd_clk);
            k++;
        end
        m_ready = 1'b1;
        enable = 1'b1;
        hold_empty = 1'b0;
        repeat (3) @(negedge rd_clk);
        checks++; if (mon_n - n0 !== 2000) begin errors++; $display("FAIL rand_count got=%0d want=2000", mon_n - n0); end
        for (int i = 0; i < 2000; i++) begin
            checks++;
            if (odata[n0+i] !== word_t'(5000 + i) || olast[n0+i] !== (i % 16 == 15)) begin
                errors++; $display("FAIL rand_word[%0d] got=%0d/%b want=%0d/%b", i, odata[n0+i], olast[n0+i], 5000 + i, (i % 16 == 15));
            end
        end
        checks++; if (pkt_cnt !== 16'd125) begin errors++; $display("FAIL rand_pkt got=%0d want=125", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
